// File: rtl/ai_player_pkg.sv
// Shared game definitions: cell codes, FSM states, line and preference tables.
package ai_player_pkg;

    localparam int unsigned CELL_W    = 2;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned BOARD_W   = CELL_W * NUM_CELLS;
    localparam int unsigned IDX_W     = 4;

    typedef enum logic [CELL_W-1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b10,
        CELL_O     = 2'b11
    } cell_e;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_WIN,
        SCAN_BLOCK,
        SCAN_PREF,
        WRITE,
        WAIT
    } state_e;

    // Three cell addresses forming one winning line.
    typedef struct packed {
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
    } line_t;

    localparam logic [ADDR_W-1:0] NO_CELL   = 4'hF;
    localparam logic [IDX_W-1:0]  LAST_LINE = 4'd7;
    localparam logic [IDX_W-1:0]  LAST_PREF = 4'd8;

    // Line table: rows, columns, then the two diagonals.
    function automatic line_t line_at(input logic [2:0] idx);
        case (idx)
            3'd0:    line_at = '{4'd0, 4'd1, 4'd2};
            3'd1:    line_at = '{4'd3, 4'd4, 4'd5};
            3'd2:    line_at = '{4'd6, 4'd7, 4'd8};
            3'd3:    line_at = '{4'd0, 4'd3, 4'd6};
            3'd4:    line_at = '{4'd1, 4'd4, 4'd7};
            3'd5:    line_at = '{4'd2, 4'd5, 4'd8};
            3'd6:    line_at = '{4'd0, 4'd4, 4'd8};
            default: line_at = '{4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    // Preference order: center, corners, then edges.
    function automatic logic [ADDR_W-1:0] pref_at(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    pref_at = 4'd4;
            4'd1:    pref_at = 4'd0;
            4'd2:    pref_at = 4'd2;
            4'd3:    pref_at = 4'd6;
            4'd4:    pref_at = 4'd8;
            4'd5:    pref_at = 4'd1;
            4'd6:    pref_at = 4'd3;
            4'd7:    pref_at = 4'd5;
            default: pref_at = 4'd7;
        endcase
    endfunction

    // Extract one cell from a board image; out-of-range addresses read as occupied.
    function automatic logic [CELL_W-1:0] cell_of(input logic [BOARD_W-1:0] board,
                                                   input logic [ADDR_W-1:0] addr);
        cell_of = 2'b01;
        for (int i = 0; i < int'(NUM_CELLS); i++) begin
            if (addr == ADDR_W'(i)) cell_of = board[CELL_W*i +: CELL_W];
        end
    endfunction

endpackage

// File: rtl/ai_player_line_eval.sv
// line_eval: flags a line holding exactly two target symbols plus one empty cell.
module ai_player_line_eval
    import ai_player_pkg::*;
(
    input  logic [CELL_W-1:0] c0,
    input  logic [CELL_W-1:0] c1,
    input  logic [CELL_W-1:0] c2,
    input  logic [CELL_W-1:0] sym,
    input  line_t             line,
    output logic              hit_c,
    output logic [ADDR_W-1:0] addr_c
);

    logic s0, s1, s2, e0, e1, e2;

    // Two-of-symbol plus one-empty match and the address of the empty cell.
    always_comb begin
        s0 = (c0 == sym);
        s1 = (c1 == sym);
        s2 = (c2 == sym);
        e0 = (c0 == CELL_EMPTY);
        e1 = (c1 == CELL_EMPTY);
        e2 = (c2 == CELL_EMPTY);
        hit_c  = (s0 & s1 & e2) | (s0 & e1 & s2) | (e0 & s1 & s2);
        addr_c = NO_CELL;
        if (hit_c) begin
            if (e0)      addr_c = line.a0;
            else if (e1) addr_c = line.a1;
            else         addr_c = line.a2;
        end
    end

endmodule

// File: rtl/ai_player.sv
// Tic-tac-toe computer player: win, else block, else take a preferred cell.
module ai_player
    import ai_player_pkg::*;
#(
    parameter logic [1:0] AI_SYMBOL = 2'b11
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               myTurn,
    input  logic               gameIsDone,
    input  logic [BOARD_W-1:0] gBoard,
    output logic [ADDR_W-1:0]  playerInput,
    output logic               playerWrite,
    output logic               busy,
    output logic               noMove
);

    localparam logic [1:0] OPP_SYMBOL = (AI_SYMBOL == CELL_O) ? CELL_X : CELL_O;

    state_e             state, next_state;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [BOARD_W-1:0] snapshot, snapshot_n;
    logic [ADDR_W-1:0]  cell_q, cell_n;
    logic               no_move_n, write_n, busy_n;
    logic [ADDR_W-1:0]  addr_n;

    line_t              ln;
    logic [CELL_W-1:0]  sym;
    logic               hit;
    logic [ADDR_W-1:0]  hit_addr;
    logic [ADDR_W-1:0]  pref_addr;
    logic               pref_empty;

    // Current line and preference cell under test, drawn from the snapshot.
    always_comb begin
        ln         = line_at(idx[2:0]);
        sym        = (state == SCAN_BLOCK) ? OPP_SYMBOL : AI_SYMBOL;
        pref_addr  = pref_at(idx);
        pref_empty = (cell_of(snapshot, pref_addr) == CELL_EMPTY);
    end

    ai_player_line_eval u_line_eval (
        .c0     (cell_of(snapshot, ln.a0)),
        .c1     (cell_of(snapshot, ln.a1)),
        .c2     (cell_of(snapshot, ln.a2)),
        .sym    (sym),
        .line   (ln),
        .hit_c  (hit),
        .addr_c (hit_addr)
    );

    // Next-state, datapath and next-output logic.
    always_comb begin
        next_state = state;
        idx_n      = idx;
        snapshot_n = snapshot;
        cell_n     = cell_q;
        no_move_n  = noMove;

        case (state)
            IDLE: begin
                if (myTurn && !gameIsDone) begin
                    snapshot_n = gBoard;
                    idx_n      = '0;
                    no_move_n  = 1'b0;
                    next_state = SCAN_WIN;
                end
            end
            SCAN_WIN, SCAN_BLOCK: begin
                if (hit) begin
                    cell_n     = hit_addr;
                    next_state = WRITE;
                end else if (idx == LAST_LINE) begin
                    idx_n      = '0;
                    next_state = (state == SCAN_WIN) ? SCAN_BLOCK : SCAN_PREF;
                end else begin
                    idx_n = idx + IDX_W'(1);
                end
            end
            SCAN_PREF: begin
                if (pref_empty) begin
                    cell_n     = pref_addr;
                    next_state = WRITE;
                end else if (idx == LAST_PREF) begin
                    no_move_n  = 1'b1;
                    next_state = WAIT;
                end else begin
                    idx_n = idx + IDX_W'(1);
                end
            end
            WRITE: next_state = WAIT;
            WAIT:  if (!myTurn) next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // Losing the turn mid-scan or the game ending abandons the move.
        if ((state == SCAN_WIN || state == SCAN_BLOCK || state == SCAN_PREF) && !myTurn)
            next_state = IDLE;
        if (gameIsDone)
            next_state = IDLE;

        write_n = (next_state == WRITE);
        addr_n  = write_n ? cell_n : NO_CELL;
        busy_n  = (next_state != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            snapshot    <= '0;
            cell_q      <= '0;
            playerInput <= NO_CELL;
            playerWrite <= 1'b0;
            busy        <= 1'b0;
            noMove      <= 1'b0;
        end else begin
            state       <= next_state;
            idx         <= idx_n;
            snapshot    <= snapshot_n;
            cell_q      <= cell_n;
            playerInput <= addr_n;
            playerWrite <= write_n;
            busy        <= busy_n;
            noMove      <= no_move_n;
        end
    end

endmodule

// File: tb/tb_ai_player.sv
// Self-checking bench for ai_player with an expected-move scoreboard.
module tb_ai_player;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        myTurn;
    logic        gameIsDone;
    logic [17:0] gBoard;
    logic [3:0]  playerInput;
    logic        playerWrite;
    logic        busy;
    logic        noMove;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic       w;
        logic [3:0] a;
        int         lat;
    } move_t;

    move_t sb[$];

    ai_player #(.AI_SYMBOL(2'b11)) dut (
        .ph1         (ph1),
        .reset       (reset),
        .myTurn      (myTurn),
        .gameIsDone  (gameIsDone),
        .gBoard      (gBoard),
        .playerInput (playerInput),
        .playerWrite (playerWrite),
        .busy        (busy),
        .noMove      (noMove)
    );

    always #5 ph1 = ~ph1;

    // Board from a 9-char string: '.' empty, 'X', 'O'.
    function automatic logic [17:0] bd(input string s);
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) begin
            if (s[i] == "X")      b[2*i +: 2] = 2'b10;
            else if (s[i] == "O") b[2*i +: 2] = 2'b11;
        end
        return b;
    endfunction

    // Reference player: expected cell and latency (edges from the sampling edge).
    function automatic move_t model(input logic [17:0] b);
        int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        int pref [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
        logic [1:0] syms [2] = '{2'b11, 2'b10};
        move_t m;
        logic found;
        m = '{w: 1'b0, a: 4'hF, lat: 0};
        found = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int l = 0; l < 8; l++) begin
                int ns, ne, emp;
                ns = 0; ne = 0; emp = 0;
                for (int k = 0; k < 3; k++) begin
                    if (b[2*lines[l][k] +: 2] == syms[p]) ns++;
                    else if (b[2*lines[l][k] +: 2] == 2'b00) begin ne++; emp = lines[l][k]; end
                end
                if (!found && ns == 2 && ne == 1) begin
                    found = 1'b1;
                    m = '{w: 1'b1, a: 4'(emp), lat: p*8 + l + 2};
                end
            end
        end
        for (int k = 0; k < 9; k++) begin
            if (!found && b[2*pref[k] +: 2] == 2'b00) begin
                found = 1'b1;
                m = '{w: 1'b1, a: 4'(pref[k]), lat: 18 + k};
            end
        end
        return m;
    endfunction

    // Drive one full turn and record what the player did.
    task automatic run_move(input logic [17:0] b, input logic [17:0] alt, input int alt_cyc,
                            output int pulses, output logic [3:0] got_a, output int got_lat,
                            output logic nm, output logic bz, output logic idle_ok);
        pulses = 0; got_a = 4'hF; got_lat = 0; idle_ok = 1'b0;
        @(negedge ph1);
        gBoard = b;
        myTurn = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge ph1); #1;
            if (playerWrite) begin
                if (pulses == 0) begin got_a = playerInput; got_lat = cyc; end
                pulses++;
            end
            if (alt_cyc == cyc) gBoard = alt;
        end
        nm = noMove;
        bz = busy;
        @(negedge ph1);
        myTurn = 1'b0;
        gBoard = '0;
        for (int i = 0; i < 5 && !idle_ok; i++) begin
            @(posedge ph1); #1;
            if (!busy) idle_ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; myTurn = 1'b0; gameIsDone = 1'b0; gBoard = '0;
        repeat (2) @(posedge ph1);
        #1;
        n_total++;
        if (playerInput !== 4'hF) $display("FAIL reset_addr: got %h expected f", playerInput); else n_pass++;
        n_total++;
        if (playerWrite !== 1'b0) $display("FAIL reset_write: got %b expected 0", playerWrite); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++;
        if (noMove !== 1'b0) $display("FAIL reset_nomove: got %b expected 0", noMove); else n_pass++;
        @(negedge ph1);
        reset = 1'b1;
    endtask

    // Table of boards covering win, block, preference, first-hit and full cases.
    task automatic test_moves();
        string boards [8] = '{".........", "OO..X...X", "X..XO....", "OO.OO.XXX",
                              "X.O.O...X", "XOXOXXO.X", "XOXOXXOXO", "XX.O.O..."};
        logic [17:0] b;
        move_t e;
        int pulses, lat;
        logic [3:0] a;
        logic nm, bz, ok;
        for (int t = 0; t < 14; t++) begin
            if (t < 8) b = bd(boards[t]);
            else begin
                b = '0;
                for (int c = 0; c < 9; c++) begin
                    int r;
                    r = int'($urandom_range(0, 2));
                    b[2*c +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
                end
            end
            sb.push_back(model(b));
            run_move(b, '0, 0, pulses, a, lat, nm, bz, ok);
            e = sb.pop_front();
            n_total++;
            if (pulses !== (e.w ? 1 : 0)) $display("FAIL move%0d_pulses: got %0d expected %0d", t, pulses, e.w ? 1 : 0); else n_pass++;
            if (e.w) begin
                n_total++;
                if (a !== e.a) $display("FAIL move%0d_cell: got %0d expected %0d", t, a, e.a); else n_pass++;
                n_total++;
                if (lat !== e.lat) $display("FAIL move%0d_latency: got %0d expected %0d", t, lat, e.lat); else n_pass++;
            end
            n_total++;
            if (nm !== !e.w) $display("FAIL move%0d_nomove: got %b expected %b", t, nm, !e.w); else n_pass++;
            n_total++;
            if (bz !== 1'b1) $display("FAIL move%0d_busy_wait: got %b expected 1", t, bz); else n_pass++;
            n_total++;
            if (ok !== 1'b1) $display("FAIL move%0d_idle_return: got %b expected 1", t, ok); else n_pass++;
        end
    endtask

    // Board edits after the snapshot must not change the chosen move.
    task automatic test_snapshot();
        move_t e;
        int pulses, lat;
        logic [3:0] a;
        logic nm, bz, ok;
        sb.push_back(model(bd(".........")));
        run_move(bd("........."), bd("OO......."), 2, pulses, a, lat, nm, bz, ok);
        e = sb.pop_front();
        n_total++;
        if (a !== e.a) $display("FAIL snapshot_cell: got %0d expected %0d", a, e.a); else n_pass++;
        n_total++;
        if (lat !== e.lat) $display("FAIL snapshot_latency: got %0d expected %0d", lat, e.lat); else n_pass++;
    endtask

    // Holding myTurn for 100 cycles yields one write only.
    task automatic test_long_turn();
        move_t e;
        int pulses;
        logic [3:0] a;
        sb.push_back(model(bd("OO..X...X")));
        pulses = 0; a = 4'hF;
        @(negedge ph1);
        gBoard = bd("OO..X...X");
        myTurn = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge ph1); #1;
            if (playerWrite) begin pulses++; a = playerInput; end
        end
        @(negedge ph1);
        myTurn = 1'b0;
        repeat (2) @(posedge ph1);
        e = sb.pop_front();
        n_total++;
        if (pulses !== 1) $display("FAIL long_turn_pulses: got %0d expected 1", pulses); else n_pass++;
        n_total++;
        if (a !== e.a) $display("FAIL long_turn_cell: got %0d expected %0d", a, e.a); else n_pass++;
    endtask

    // Reset, gameIsDone and myTurn drop during a scan all cancel the write.
    task automatic test_interrupts();
        int pulses;
        for (int mode = 0; mode < 3; mode++) begin
            sb.push_back('{w: 1'b0, a: 4'hF, lat: 0});
            pulses = 0;
            @(negedge ph1);
            gBoard = '0;
            myTurn = 1'b1;
            repeat (4) @(posedge ph1);
            #2;
            if (mode == 0) begin
                reset = 1'b0;
                #1;
                n_total++;
                if (playerInput !== 4'hF || playerWrite !== 1'b0 || busy !== 1'b0 || noMove !== 1'b0)
                    $display("FAIL reset_midscan_outputs: got addr=%h wr=%b busy=%b nm=%b expected f/0/0/0",
                             playerInput, playerWrite, busy, noMove);
                else n_pass++;
                myTurn = 1'b0;
                @(negedge ph1);
                reset = 1'b1;
            end else begin
                if (mode == 1) gameIsDone = 1'b1;
                else           myTurn = 1'b0;
                @(posedge ph1); #1;
                n_total++;
                if (busy !== 1'b0) $display("FAIL interrupt%0d_idle: got busy=%b expected 0", mode, busy); else n_pass++;
            end
            for (int cyc = 0; cyc < 30; cyc++) begin
                @(posedge ph1); #1;
                if (playerWrite) pulses++;
            end
            @(negedge ph1);
            gameIsDone = 1'b0;
            myTurn = 1'b0;
            repeat (2) @(posedge ph1);
            n_total++;
            if (pulses !== (sb.pop_front().w ? 1 : 0))
                $display("FAIL interrupt%0d_nowrite: got %0d pulses expected 0", mode, pulses);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_snapshot();
        test_long_turn();
        test_interrupts();
        test_moves();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
